// File: rtl/overcooked_pkg.sv
// Shared arena geometry and player enums for game logic, renderer and player_move.
package overcooked_pkg;

  localparam int unsigned TILE_PX = 32;
  localparam int unsigned GRID_W  = 13;
  localparam int unsigned GRID_H  = 8;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    CHOP = 2'd2
  } act_t;

endpackage

// File: rtl/player_move_rise_edge.sv
// Rising-edge detector evaluated only on frame ticks: compares a level
// against its value at the previous tick.
module rise_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  // Remember the level seen at the most recent tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else if (tick_i) begin
      prev_q <= level_i;
    end
  end

  assign rise_o = tick_i & level_i & ~prev_q;

endmodule

// File: rtl/player_move.sv
// Player movement / chop controller. One instance per player.
// Steps once per frame tick, checking each step against the tile map via a
// one-cycle query handshake. Optional macro PLAYER_MOVE_SPRINT_EN adds
// sprint_in, which doubles the step while high.
module player_move #(
  parameter int unsigned TILE_PX     = overcooked_pkg::TILE_PX,
  parameter int unsigned GRID_W      = overcooked_pkg::GRID_W,
  parameter int unsigned GRID_H      = overcooked_pkg::GRID_H,
  parameter int unsigned STEP_PX     = 2,
  parameter int unsigned CHOP_FRAMES = 60,
  parameter int unsigned START_X     = 32,
  parameter int unsigned START_Y     = 32
) (
  input  logic       clock_in,
  input  logic       reset_in_n,
  input  logic       frame_tick_in,
  input  logic       up_in,
  input  logic       down_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       chop_in,
  input  logic       carry_in,
`ifdef PLAYER_MOVE_SPRINT_EN
  input  logic       sprint_in,
`endif
  output logic       query_valid_out,
  output logic [3:0] query_col_out,
  output logic [2:0] query_row_out,
  input  logic       tile_blocked_in,
  output logic [8:0] player_loc_x,
  output logic [8:0] player_loc_y,
  output logic [1:0] player_direction,
  output logic [3:0] player_state,
  output logic       chop_done_out
);

  typedef enum logic [1:0] {S_IDLE, S_QUERY, S_WAIT, S_CHOP} fsm_t;

  localparam int unsigned TILE_SH  = $clog2(TILE_PX);
  localparam int unsigned CNT_W    = $clog2(CHOP_FRAMES + 1);
  localparam logic [9:0]  MAX_X10  = 10'((GRID_W - 1) * TILE_PX);
  localparam logic [9:0]  MAX_Y10  = 10'((GRID_H - 1) * TILE_PX);
  localparam logic [9:0]  HALF10   = 10'(TILE_PX / 2);
  localparam logic [9:0]  TILE_M1  = 10'(TILE_PX - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHOP_FRAMES - 1);

  fsm_t                 state_q, state_d;
  logic [8:0]           x_q, x_d, y_q, y_d;
  logic [8:0]           cx_q, cx_d, cy_q, cy_d;
  overcooked_pkg::dir_t dir_q, dir_d;
  overcooked_pkg::act_t act_q, act_d;
  logic [3:0]           col_q, col_d;
  logic [2:0]           row_q, row_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 qv_q, done_q, done_d, carry_q;

  logic                 chop_rise, dir_held, cand_moves;
  logic [9:0]           step_w, xw, yw, cand_x, cand_y, lead_col, lead_row;
  overcooked_pkg::dir_t cand_dir;

  rise_edge u_chop_edge (
    .clk_i   (clock_in),
    .rst_ni  (reset_in_n),
    .tick_i  (frame_tick_in),
    .level_i (chop_in),
    .rise_o  (chop_rise)
  );

  assign dir_held = up_in | down_in | left_in | right_in;

  // Clamped candidate for the highest-priority held direction and the tile
  // under its leading edge
  always_comb begin
    step_w = 10'(STEP_PX);
`ifdef PLAYER_MOVE_SPRINT_EN
    if (sprint_in) step_w = 10'(2 * STEP_PX);
`endif
    xw       = {1'b0, x_q};
    yw       = {1'b0, y_q};
    cand_x   = xw;
    cand_y   = yw;
    cand_dir = dir_q;
    lead_col = '0;
    lead_row = '0;
    if (up_in) begin
      cand_dir = overcooked_pkg::UP;
      cand_y   = (yw < step_w) ? '0 : yw - step_w;
      lead_row = cand_y;
      lead_col = xw + HALF10;
    end else if (down_in) begin
      cand_dir = overcooked_pkg::DOWN;
      cand_y   = (yw + step_w > MAX_Y10) ? MAX_Y10 : yw + step_w;
      lead_row = cand_y + TILE_M1;
      lead_col = xw + HALF10;
    end else if (left_in) begin
      cand_dir = overcooked_pkg::LEFT;
      cand_x   = (xw < step_w) ? '0 : xw - step_w;
      lead_col = cand_x;
      lead_row = yw + HALF10;
    end else if (right_in) begin
      cand_dir = overcooked_pkg::RIGHT;
      cand_x   = (xw + step_w > MAX_X10) ? MAX_X10 : xw + step_w;
      lead_col = cand_x + TILE_M1;
      lead_row = yw + HALF10;
    end
    cand_moves = (cand_x != xw) || (cand_y != yw);
  end

  // Next-state logic for movement, tile query and chop progress
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dir_d   = dir_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick_in) begin
          if (chop_rise) begin
            state_d = S_CHOP;
            cnt_d   = '0;
          end else if (dir_held) begin
            dir_d = cand_dir;
            if (cand_moves) begin
              cx_d    = cand_x[8:0];
              cy_d    = cand_y[8:0];
              col_d   = 4'(lead_col >> TILE_SH);
              row_d   = 3'(lead_row >> TILE_SH);
              state_d = S_QUERY;
            end
          end
        end
      end
      S_QUERY: state_d = S_WAIT;
      S_WAIT: begin
        if (!tile_blocked_in) begin
          x_d = cx_q;
          y_d = cy_q;
        end
        state_d = S_IDLE;
      end
      S_CHOP: begin
        if (!chop_in) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (frame_tick_in) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_CHOP)      act_d = overcooked_pkg::CHOP;
    else if (state_d != S_IDLE) act_d = overcooked_pkg::WALK;
    else if (dir_held)          act_d = overcooked_pkg::WALK;
    else                        act_d = overcooked_pkg::IDLE;
  end

  // State and output registers
  always_ff @(posedge clock_in or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q <= S_IDLE;
      x_q     <= 9'(START_X);
      y_q     <= 9'(START_Y);
      cx_q    <= 9'(START_X);
      cy_q    <= 9'(START_Y);
      dir_q   <= overcooked_pkg::DOWN;
      act_q   <= overcooked_pkg::IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      qv_q    <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dir_q   <= dir_d;
      act_q   <= act_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      qv_q    <= (state_d == S_QUERY);
      done_q  <= done_d;
      carry_q <= carry_in;
    end
  end

  assign query_valid_out  = qv_q;
  assign query_col_out    = col_q;
  assign query_row_out    = row_q;
  assign player_loc_x     = x_q;
  assign player_loc_y     = y_q;
  assign player_direction = dir_q;
  assign player_state     = {1'b0, carry_q, act_q};
  assign chop_done_out    = done_q;

endmodule

// File: tb/tb_player_move.sv
// Bench for player_move: frame-level reference model plus directed vectors.
module tb_player_move;

  localparam int TILE  = 32;
  localparam int MAXX  = 12 * TILE;
  localparam int MAXY  = 7 * TILE;
  localparam int STEP  = 2;
  localparam int NCHOP = 60;

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0, chop = 1'b0, carry = 1'b0, blocked = 1'b0;
  logic       qv_o, done_o;
  logic [3:0] col_o, st_o;
  logic [2:0] row_o;
  logic [8:0] x_o, y_o;
  logic [1:0] dir_o;

  int n_pass = 0, n_total = 0, done_seen = 0;
  bit chk_en = 1'b0;

  // reference model state (phase: 0 idle, 1 query, 2 wait, 3 chop)
  int m_x, m_y, m_dir, m_phase, m_cnt, m_cx, m_cy, m_col, m_row, m_act;
  bit m_prev, m_rise, m_qv, m_done, m_carry;

  player_move dut (
    .clock_in        (clk),
    .reset_in_n      (rst_n),
    .frame_tick_in   (tick),
    .up_in           (up),
    .down_in         (dn),
    .left_in         (lf),
    .right_in        (rt),
    .chop_in         (chop),
    .carry_in        (carry),
`ifdef PLAYER_MOVE_SPRINT_EN
    .sprint_in       (1'b0),
`endif
    .query_valid_out (qv_o),
    .query_col_out   (col_o),
    .query_row_out   (row_o),
    .tile_blocked_in (blocked),
    .player_loc_x    (x_o),
    .player_loc_y    (y_o),
    .player_direction(dir_o),
    .player_state    (st_o),
    .chop_done_out   (done_o)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference model, advanced once per clock edge
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_x = 32; m_y = 32; m_dir = 1; m_phase = 0; m_cnt = 0; m_prev = 0;
      m_cx = 32; m_cy = 32; m_col = 0; m_row = 0;
      m_qv = 0; m_done = 0; m_carry = 0; m_act = 0;
    end else begin
      m_done = 0;
      m_rise = tick && chop && !m_prev;
      if (tick) m_prev = chop;
      if (m_phase == 0) begin
        if (tick && m_rise) begin
          m_phase = 3;
          m_cnt = 0;
        end else if (tick && (up || dn || lf || rt)) begin
          m_dir = up ? 0 : dn ? 1 : lf ? 2 : 3;
          m_cx = m_x;
          m_cy = m_y;
          if (m_dir == 0) m_cy = clampi(m_y - STEP, MAXY);
          if (m_dir == 1) m_cy = clampi(m_y + STEP, MAXY);
          if (m_dir == 2) m_cx = clampi(m_x - STEP, MAXX);
          if (m_dir == 3) m_cx = clampi(m_x + STEP, MAXX);
          if (m_cx != m_x || m_cy != m_y) begin
            if (m_dir < 2) begin
              m_col = (m_x + TILE / 2) / TILE;
              m_row = (m_dir == 0) ? m_cy / TILE : (m_cy + TILE - 1) / TILE;
            end else begin
              m_row = (m_y + TILE / 2) / TILE;
              m_col = (m_dir == 2) ? m_cx / TILE : (m_cx + TILE - 1) / TILE;
            end
            m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2) begin
        if (!blocked) begin
          m_x = m_cx;
          m_y = m_cy;
        end
        m_phase = 0;
      end else begin
        if (!chop) begin
          m_phase = 0;
          m_cnt = 0;
        end else if (tick) begin
          m_cnt++;
          if (m_cnt == NCHOP) begin
            m_done = 1;
            m_phase = 0;
            m_cnt = 0;
          end
        end
      end
      m_qv = (m_phase == 1);
      m_carry = carry;
      if (m_phase == 3) m_act = 2;
      else if (m_phase != 0) m_act = 1;
      else m_act = (up || dn || lf || rt) ? 1 : 0;
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("x", int'(x_o), m_x);
      check("y", int'(y_o), m_y);
      check("dir", int'(dir_o), m_dir);
      check("state", int'(st_o), (m_carry ? 4 : 0) + m_act);
      check("qvalid", int'(qv_o), int'(m_qv));
      check("done", int'(done_o), int'(m_done));
      if (m_qv) begin
        check("qcol", int'(col_o), m_col);
        check("qrow", int'(row_o), m_row);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_o) done_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One frame tick, then enough idle cycles for a query to complete
  task automatic frame(output bit qv, output int col, output int row);
    @(posedge clk); #2 tick = 1'b1;
    @(posedge clk); #2 tick = 1'b0;
    qv = qv_o;
    col = int'(col_o);
    row = int'(row_o);
    cyc(3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    bit qv;
    int col, row;
    cyc(3);
    chk_en = 1'b1;
    rst_n = 1'b1;
    cyc(2);
    check("rst_x", int'(x_o), 32);
    check("rst_y", int'(y_o), 32);
    check("rst_dir", int'(dir_o), 1);
    check("rst_state", int'(st_o), 0);
    check("rst_qv", int'(qv_o), 0);
    check("rst_done", int'(done_o), 0);

    // walk right, open floor
    rt = 1'b1;
    frame(qv, col, row);
    check("r_qv", int'(qv), 1);
    check("r_col", col, 2);
    check("r_row", row, 1);
    check("r_x1", int'(x_o), 34);
    frame(qv, col, row);
    check("r_x2", int'(x_o), 36);
    frame(qv, col, row);
    check("r_x3", int'(x_o), 38);
    check("r_dir", int'(dir_o), 3);
    check("r_act", int'(st_o) & 3, 1);
    rt = 1'b0;

    // blocked left step
    do_reset();
    lf = 1'b1;
    blocked = 1'b1;
    frame(qv, col, row);
    check("l_qv", int'(qv), 1);
    check("l_col", col, 0);
    check("l_row", row, 1);
    check("l_x", int'(x_o), 32);
    check("l_dir", int'(dir_o), 2);
    lf = 1'b0;
    blocked = 1'b0;

    // right wall clamp
    do_reset();
    rt = 1'b1;
    repeat (176) frame(qv, col, row);
    check("wall_x", int'(x_o), 384);
    frame(qv, col, row);
    check("wall_qv", int'(qv), 0);
    check("wall_x2", int'(x_o), 384);
    check("wall_dir", int'(dir_o), 3);
    rt = 1'b0;

    // top wall clamp and down query from the top row
    up = 1'b1;
    frame(qv, col, row);
    check("u_col", col, 12);
    check("u_row", row, 0);
    check("u_y", int'(y_o), 30);
    repeat (15) frame(qv, col, row);
    check("top_y", int'(y_o), 0);
    frame(qv, col, row);
    check("top_qv", int'(qv), 0);
    check("top_dir", int'(dir_o), 0);
    up = 1'b0;
    dn = 1'b1;
    frame(qv, col, row);
    check("d_col", col, 12);
    check("d_row", row, 1);
    check("d_y", int'(y_o), 2);
    dn = 1'b0;

    // ticks during QUERY and WAIT are dropped
    do_reset();
    rt = 1'b1;
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    cyc(2);
    check("drop_x", int'(x_o), 34);
    rt = 1'b0;

    // full chop with right held
    do_reset();
    done_seen = 0;
    rt = 1'b1;
    chop = 1'b1;
    frame(qv, col, row);
    check("chop_act", int'(st_o) & 3, 2);
    repeat (NCHOP - 1) frame(qv, col, row);
    check("chop_nodone", done_seen, 0);
    check("chop_act59", int'(st_o) & 3, 2);
    frame(qv, col, row);
    check("chop_done", done_seen, 1);
    check("chop_x", int'(x_o), 32);
    check("chop_after", int'(st_o) & 3, 1);
    rt = 1'b0;
    chop = 1'b0;
    cyc(2);
    check("chop_idle", int'(st_o) & 3, 0);

    // aborted chop
    frame(qv, col, row);
    done_seen = 0;
    chop = 1'b1;
    frame(qv, col, row);
    repeat (30) frame(qv, col, row);
    check("abort_act", int'(st_o) & 3, 2);
    chop = 1'b0;
    cyc(2);
    check("abort_done", done_seen, 0);
    check("abort_idle", int'(st_o) & 3, 0);

    // reset while waiting on the tile answer
    do_reset();
    rt = 1'b1;
    @(posedge clk); #2 tick = 1'b1;
    @(posedge clk); #2 tick = 1'b0;
    cyc(1);
    rst_n = 1'b0;
    rt = 1'b0;
    cyc(1);
    check("rw_x", int'(x_o), 32);
    check("rw_qv", int'(qv_o), 0);
    rst_n = 1'b1;
    cyc(3);
    check("rw_x2", int'(x_o), 32);
    check("rw_y2", int'(y_o), 32);
    check("rw_qv2", int'(qv_o), 0);

    // carry flag follows the switch one cycle later
    carry = 1'b1;
    cyc(2);
    check("carry", int'(st_o), 4);
    carry = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/player_move.md
Name: player_move

Overview:
- Sits directly downstream of the per-button debouncers and upstream of game logic.
- Turns clean button levels (up/down/left/right/chop/carry) into one player's pixel position, facing direction and activity state. Position advances once per video frame.
- Each step is checked against the counter/wall map through a one-cycle tile-query handshake with game logic.
- Game logic instantiates one per player. Player position and state feed the renderer.

Parameters:
- TILE_PX, 32, tile edge in pixels (power of 2)
- GRID_W, 13, arena width in tiles
- GRID_H, 8, arena height in tiles
- STEP_PX, 2, pixels moved per accepted frame tick
- CHOP_FRAMES, 60, frame ticks of held chop needed to finish a chop
- START_X, 32, reset x pixel
- START_Y, 32, reset y pixel

Ports:
- clock_in  in  1  system clock (25 MHz pixel clock)
- reset_in_n  in  1  asynchronous, active-low reset
- frame_tick_in  in  1  one-cycle pulse per frame
- up_in, down_in, left_in, right_in, chop_in, carry_in  in  1 each  debounced button/switch levels
- query_valid_out  out  1  tile query strobe
- query_col_out  out  4  queried tile column
- query_row_out  out  3  queried tile row
- tile_blocked_in  in  1  blocked flag, valid the cycle after query_valid_out
- player_loc_x  out  9  pixel x of player's top-left corner
- player_loc_y  out  9  pixel y of player's top-left corner
- player_direction  out  2  facing: 0 up, 1 down, 2 left, 3 right
- player_state  out  4  [1:0] 0 idle, 1 walking, 2 chopping; [2] carry; [3] 0
- chop_done_out  out  1  one-cycle pulse when a chop completes

Behaviour:
- Reset (async assert, sync release):
  - x=START_X, y=START_Y, direction=1 (down)
  - state=IDLE, all pulses 0, chop counter 0
- FSM states: IDLE, QUERY, WAIT, CHOP.
- IDLE, on frame_tick_in:
  - Rising edge of chop (chop_in high now, low at the previous tick) -> CHOP, counter cleared. Chop takes priority over movement.
  - Else the first held direction in priority up>down>left>right sets player_direction.
  - Candidate = position ± STEP_PX on that axis, clamped to [0, (GRID_W-1)*TILE_PX] in x and [0, (GRID_H-1)*TILE_PX] in y.
  - If candidate equals current position: no query, stay IDLE.
  - Otherwise latch the candidate and go to QUERY.
- Queried tile is the leading edge of the candidate:
  - right: col=(xc+TILE_PX-1)/TILE_PX, row=(y+TILE_PX/2)/TILE_PX
  - left: col=xc/TILE_PX, row as for right
  - down: row=(yc+TILE_PX-1)/TILE_PX, col=(x+TILE_PX/2)/TILE_PX
  - up: row=yc/TILE_PX, col as for down
- QUERY: query_valid_out=1 for exactly one cycle, col/row stable that cycle -> WAIT.
- WAIT: sample tile_blocked_in.
  - 0 -> commit candidate to player_loc_x/y.
  - 1 -> discard candidate.
  - Either way -> IDLE. Query latency is fixed at 1 cycle; game logic must answer combinationally from registered grid.
- Frame ticks arriving in QUERY or WAIT are dropped, not queued.
- CHOP:
  - On each frame tick with chop_in high, counter++.
  - When the counter reaches CHOP_FRAMES: chop_done_out=1 for one cycle -> IDLE.
  - chop_in low on any cycle -> IDLE immediately, no done pulse, counter cleared.
  - No movement in CHOP; direction frozen.
- player_state[1:0] reflects the current cycle:
  - IDLE with no direction held -> 0
  - IDLE with a direction held, or QUERY/WAIT -> 1
  - CHOP -> 2
- player_state[2] = carry_in registered one cycle.
- All outputs registered except query_col_out/query_row_out, which are held in registers from IDLE.
- Reset mid-QUERY/WAIT: query dropped, position returns to START_X/START_Y.

Optional Feature:
- PLAYER_MOVE_SPRINT_EN defined: adds input port sprint_in (1 bit).
  - While high, step = 2*STEP_PX, with the same clamp and leading-edge query.
  - Only one tile is queried per step; TILE_PX must be >= 2*STEP_PX.
- Undefined: port absent, step always STEP_PX.

Decomposition:
- Package overcooked_pkg:
  - dir_t enum (UP=0, DOWN=1, LEFT=2, RIGHT=3)
  - act_t enum (IDLE=0, WALK=1, CHOP=2)
  - GRID_W, GRID_H, TILE_PX constants, shared with game logic and renderer
- One sub-module, rise_edge: a frame-tick-qualified rising-edge detector for chop_in.

Test Plan:
- Reset: release reset -> x=32, y=32, direction=1, player_state=0, query_valid_out=0, chop_done_out=0.
- Hold right_in, 3 frame ticks, tile_blocked_in=0:
  - first query at col=2, row=1
  - x goes 34, 36, 38
  - direction=3, player_state[1:0]=1
- At x=32, hold left_in with tile_blocked_in=1 on the WAIT cycle -> query col=0 row=1, x stays 32, direction=2.
- Force x=384, hold right_in, frame tick -> no query_valid_out pulse, x stays 384, direction=3.
- Chop:
  - press chop_in and hold 60 frame ticks with right_in also held -> chop_done_out pulses once on the 60th tick, x unchanged, state 2 then 0
  - second run released after 30 ticks -> no pulse, state back to 0
- Assert reset_in_n=0 during WAIT with a candidate pending -> position 32/32, no commit after release, query_valid_out=0.
